// File: rtl/sdes_pkg.sv
// Shared S-DES helpers: permutation tables, feeder FSM states and the
// P10 / P8 / LS primitives used by both the encrypt and decrypt feeders.
package sdes_pkg;

  typedef enum logic [2:0] {
    NOKEY = 3'd0,
    KGEN1 = 3'd1,
    KGEN2 = 3'd2,
    IDLE  = 3'd3,
    ENC   = 3'd4,
    OUT   = 3'd5
  } feeder_state_t;

  // Positions are 1-based with position 1 = MSB.
  localparam int P10_IDX [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_IDX  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};

  function automatic logic [9:0] p10(input logic [9:0] k);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      r[9-i] = k[10-P10_IDX[i]];
    end
    return r;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = k[10-P8_IDX[i]];
    end
    return r;
  endfunction

  // Rotate each 5-bit half left by n (n in 0..3).
  function automatic logic [9:0] ls(input logic [9:0] v, input logic [1:0] n);
    logic [4:0] l;
    logic [4:0] r;
    l = v[9:5];
    r = v[4:0];
    for (int i = 0; i < 3; i++) begin
      if (i < int'(n)) begin
        l = {l[3:0], l[4]};
        r = {r[3:0], r[4]};
      end
    end
    return {l, r};
  endfunction

endpackage

// File: rtl/sdes_cbc_feeder_if.sv
// Plaintext-in / ciphertext-out byte streams of the CBC feeder.
// master = producer of plaintext and consumer of ciphertext; slave = feeder.
interface sdes_cbc_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sdes_keysched_seq.sv
// Two-cycle S-DES key schedule: the start cycle produces K1, the following
// cycle produces K2 (done high). Subkeys then hold until the next start.
module sdes_keysched_seq
  import sdes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] key,
  output logic       done,
  output logic [7:0] subkey1,
  output logic [7:0] subkey2
);

  logic [9:0] halves_q;
  logic       step2_q;
  logic [9:0] halves_ls1;
  logic [9:0] halves_ls2;

  assign halves_ls1 = ls(p10(key), 2'd1);
  assign halves_ls2 = ls(halves_q, 2'd2);
  assign done       = step2_q;

  // Step through LS1 -> K1, then LS2 -> K2; subkeys are only written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halves_q <= '0;
      step2_q  <= 1'b0;
      subkey1  <= '0;
      subkey2  <= '0;
    end else begin
      step2_q <= start;
      if (start) begin
        halves_q <= halves_ls1;
        subkey1  <= p8(halves_ls1);
      end else if (step2_q) begin
        halves_q <= halves_ls2;
        subkey2  <= p8(halves_ls2);
      end
    end
  end

endmodule

// File: rtl/sdes_cbc_feeder.sv
// Sequential front end for the combinational S-DES encrypt datapath:
// key schedule, CBC chaining, and valid/ready plaintext/ciphertext streams.
module sdes_cbc_feeder
  import sdes_pkg::*;
#(
  parameter bit CBC_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_load,
  input  logic [9:0]           key_in,
  input  logic [7:0]           iv_in,
  output logic                 key_ready_o,
  sdes_cbc_feeder_if.slave     bus,
  output logic [7:0]           enc_pt_o,
  output logic [7:0]           subkey1_o,
  output logic [7:0]           subkey2_o,
  input  logic [7:0]           enc_ct_i
);

  feeder_state_t state_q;
  feeder_state_t state_d;

  logic [9:0] key_q;
  logic [7:0] iv_q;
  logic [7:0] chain_q;
  logic [7:0] out_data_q;

  logic load_acc;
  logic in_acc;
  logic ks_start;
  logic ks_done;

  sdes_keysched_seq u_keysched (
    .clk     (clk),
    .rst     (rst),
    .start   (ks_start),
    .key     (key_q),
    .done    (ks_done),
    .subkey1 (subkey1_o),
    .subkey2 (subkey2_o)
  );

  assign bus.out_data = out_data_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NOKEY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; key_load wins over in_valid in IDLE,
  // and in_ready/out_valid are never high together (no bypass path).
  always_comb begin
    state_d       = state_q;
    load_acc      = 1'b0;
    in_acc        = 1'b0;
    ks_start      = 1'b0;
    key_ready_o   = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      NOKEY: begin
        if (key_load) begin
          load_acc = 1'b1;
          state_d  = KGEN1;
        end
      end
      KGEN1: begin
        ks_start = 1'b1;
        state_d  = KGEN2;
      end
      KGEN2: begin
        if (ks_done) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        key_ready_o  = 1'b1;
        bus.in_ready = ~key_load;
        if (key_load) begin
          load_acc = 1'b1;
          state_d  = KGEN1;
        end else if (bus.in_valid) begin
          in_acc  = 1'b1;
          state_d = ENC;
        end
      end
      ENC: begin
        state_d = OUT;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = NOKEY;
      end
    endcase
  end

  // Key/IV capture, chaining value, datapath plaintext and ciphertext capture.
  // enc_pt_o only moves on an accepted byte so the encrypt path is stable in ENC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q      <= '0;
      iv_q       <= '0;
      chain_q    <= '0;
      enc_pt_o   <= '0;
      out_data_q <= '0;
    end else begin
      if (load_acc) begin
        key_q <= key_in;
        iv_q  <= iv_in;
      end
      if (state_q == KGEN2) begin
        chain_q <= iv_q;
      end
      if (in_acc) begin
        enc_pt_o <= CBC_EN ? (bus.in_data ^ chain_q) : bus.in_data;
      end
      if (state_q == ENC) begin
        out_data_q <= enc_ct_i;
        if (CBC_EN) begin
          chain_q <= enc_ct_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdes_cbc_feeder.sv
// Bench for sdes_cbc_feeder: a CBC and an ECB instance driven in lockstep,
// each closed through a behavioural S-DES encrypt datapath.
module tb_sdes_cbc_feeder;

  logic       clk;
  logic       rst;
  logic       key_load;
  logic [9:0] key_in;
  logic [7:0] iv_in;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       kr_c, kr_e;
  logic [7:0] pt_c, pt_e, k1_c, k1_e, k2_c, k2_e, ct_c, ct_e;

  int n_chk  = 0;
  int n_pass = 0;

  sdes_cbc_feeder_if ifc ();
  sdes_cbc_feeder_if ife ();

  assign ifc.in_valid  = in_valid;
  assign ifc.in_data   = in_data;
  assign ifc.out_ready = out_ready;
  assign ife.in_valid  = in_valid;
  assign ife.in_data   = in_data;
  assign ife.out_ready = out_ready;

  localparam int P10T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int S0T  [16] = '{1,0,3,2, 3,2,1,0, 0,2,1,3, 3,1,3,2};
  localparam int S1T  [16] = '{0,1,2,3, 2,0,1,3, 3,0,1,0, 2,1,0,3};

  function automatic logic [7:0] ref_subkey(input logic [9:0] key, input int which);
    logic [9:0] a;
    logic [4:0] l, r;
    logic [7:0] k;
    int sh;
    a = '0;
    k = '0;
    for (int i = 0; i < 10; i++) a[9-i] = key[10-P10T[i]];
    l = a[9:5];
    r = a[4:0];
    sh = (which == 1) ? 1 : 3;
    for (int s = 0; s < sh; s++) begin
      l = {l[3:0], l[4]};
      r = {r[3:0], r[4]};
    end
    a = {l, r};
    for (int i = 0; i < 8; i++) k[7-i] = a[10-P8T[i]];
    return k;
  endfunction

  function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] k);
    logic [3:0] l, r, s;
    logic [7:0] t;
    logic [1:0] s0, s1;
    l = x[7:4];
    r = x[3:0];
    t = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
    s0 = 2'(S0T[{t[7], t[4], t[6], t[5]}]);
    s1 = 2'(S1T[{t[3], t[0], t[2], t[1]}]);
    s = {s0, s1};
    return {l ^ {s[2], s[0], s[1], s[3]}, r};
  endfunction

  function automatic logic [7:0] sdes_enc(input logic [7:0] pt, input logic [7:0] k1,
                                          input logic [7:0] k2);
    logic [7:0] x;
    x = {pt[6], pt[2], pt[5], pt[7], pt[4], pt[0], pt[3], pt[1]};
    x = fk(x, k1);
    x = {x[3:0], x[7:4]};
    x = fk(x, k2);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  // Team encrypt datapath, combinational.
  assign ct_c = sdes_enc(pt_c, k1_c, k2_c);
  assign ct_e = sdes_enc(pt_e, k1_e, k2_e);

  sdes_cbc_feeder #(.CBC_EN(1'b1)) dut_cbc (
    .clk (clk), .rst (rst), .key_load (key_load), .key_in (key_in), .iv_in (iv_in),
    .key_ready_o (kr_c), .bus (ifc.slave), .enc_pt_o (pt_c),
    .subkey1_o (k1_c), .subkey2_o (k2_c), .enc_ct_i (ct_c)
  );

  sdes_cbc_feeder #(.CBC_EN(1'b0)) dut_ecb (
    .clk (clk), .rst (rst), .key_load (key_load), .key_in (key_in), .iv_in (iv_in),
    .key_ready_o (kr_e), .bus (ife.slave), .enc_pt_o (pt_e),
    .subkey1_o (k1_e), .subkey2_o (k2_e), .enc_ct_i (ct_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DUT observations gathered per instance (0 = CBC, 1 = ECB).
  logic       a_kr [2];
  logic       a_ir [2];
  logic       a_ov [2];
  logic [7:0] a_od [2];
  logic [7:0] a_pt [2];
  logic [7:0] a_k1 [2];
  logic [7:0] a_k2 [2];
  assign a_kr[0] = kr_c;          assign a_kr[1] = kr_e;
  assign a_ir[0] = ifc.in_ready;  assign a_ir[1] = ife.in_ready;
  assign a_ov[0] = ifc.out_valid; assign a_ov[1] = ife.out_valid;
  assign a_od[0] = ifc.out_data;  assign a_od[1] = ife.out_data;
  assign a_pt[0] = pt_c;          assign a_pt[1] = pt_e;
  assign a_k1[0] = k1_c;          assign a_k1[1] = k1_e;
  assign a_k2[0] = k2_c;          assign a_k2[1] = k2_e;

  // Behavioural model: key-gen countdown, block phase, chaining and data.
  bit         m_keyed = 0;
  int         m_kg    = 0;   // key-schedule cycles still to run
  int         m_blk   = 0;   // 0 none, 1 settling, 2 presenting
  logic [9:0] m_key   = '0;
  logic [7:0] m_iv    = '0;
  logic [7:0] m_k1    = '0;
  logic [7:0] m_k2    = '0;
  logic [7:0] m_pt    [2] = '{8'h00, 8'h00};
  logic [7:0] m_out   [2] = '{8'h00, 8'h00};
  logic [7:0] m_chain = '0;
  bit         m_idle;

  always @(negedge clk) begin
    if (rst) begin
      m_keyed = 0; m_kg = 0; m_blk = 0; m_key = '0; m_iv = '0;
      m_k1 = '0; m_k2 = '0; m_chain = '0;
      m_pt[0] = '0; m_pt[1] = '0; m_out[0] = '0; m_out[1] = '0;
    end
    m_idle = m_keyed && m_kg == 0 && m_blk == 0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("key_ready[%0d]", d), 32'(a_kr[d]), 32'(m_idle));
      chk($sformatf("in_ready[%0d]", d), 32'(a_ir[d]), 32'(m_idle && !key_load));
      chk($sformatf("out_valid[%0d]", d), 32'(a_ov[d]), 32'(m_blk == 2));
      chk($sformatf("out_data[%0d]", d), 32'(a_od[d]), 32'(m_out[d]));
      chk($sformatf("enc_pt[%0d]", d), 32'(a_pt[d]), 32'(m_pt[d]));
      chk($sformatf("subkey1[%0d]", d), 32'(a_k1[d]), 32'(m_k1));
      chk($sformatf("subkey2[%0d]", d), 32'(a_k2[d]), 32'(m_k2));
    end
    if (!rst) begin
      if (m_kg == 2) begin
        m_k1 = ref_subkey(m_key, 1);
        m_kg = 1;
      end else if (m_kg == 1) begin
        m_k2 = ref_subkey(m_key, 2);
        m_chain = m_iv;
        m_kg = 0;
        m_keyed = 1;
      end else if (m_blk == 1) begin
        m_out[0] = sdes_enc(m_pt[0], m_k1, m_k2);
        m_out[1] = sdes_enc(m_pt[1], m_k1, m_k2);
        m_chain = m_out[0];
        m_blk = 2;
      end else if (m_blk == 2) begin
        if (out_ready) m_blk = 0;
      end else if (key_load) begin
        m_key = key_in; m_iv = iv_in; m_kg = 2; m_keyed = 0;
      end else if (m_keyed && in_valid) begin
        m_pt[0] = in_data ^ m_chain;
        m_pt[1] = in_data;
        m_blk = 1;
      end
    end
  end

  logic [7:0] c3, exp4, nk1, nk2;
  int         n;

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; iv_in = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_ready", 32'(kr_c), 0);
    chk("rst_in_ready", 32'(ifc.in_ready), 0);
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_out_data", 32'(ifc.out_data), 0);
    rst = 1'b0;

    // Pin the reference functions with textbook values.
    chk("model_k1", 32'(ref_subkey(10'b1010000010, 1)), 32'h A4);
    chk("model_k2", 32'(ref_subkey(10'b1010000010, 2)), 32'h 43);
    chk("model_enc", 32'(sdes_enc(8'h97, 8'hA4, 8'h43)), 32'h 38);

    // 1: key schedule
    key_load = 1'b1; key_in = 10'b1010000010; iv_in = 8'h00;
    tick(); key_load = 1'b0;
    chk("t1_kr_low", 32'(kr_c), 0);
    tick(); tick();
    chk("t1_subkey1", 32'(k1_c), 32'h A4);
    chk("t1_subkey2", 32'(k2_c), 32'h 43);
    chk("t1_key_ready", 32'(kr_c), 1);

    // 2: first byte, latency N+2
    in_valid = 1'b1; in_data = 8'h97; #1;
    chk("t2_in_ready", 32'(ifc.in_ready), 1);
    tick(); in_valid = 1'b0;
    chk("t2_pt_cbc", 32'(pt_c), 32'h 97);
    chk("t2_pt_ecb", 32'(pt_e), 32'h 97);
    chk("t2_ov_n1", 32'(ifc.out_valid), 0);
    tick();
    chk("t2_ov_n2", 32'(ifc.out_valid), 1);
    chk("t2_ct_cbc", 32'(ifc.out_data), 32'h 38);
    chk("t2_ct_ecb", 32'(ife.out_data), 32'h 38);
    chk("t2_no_bypass", 32'(ifc.in_ready), 0);
    tick();
    chk("t2_back_idle", 32'(ifc.in_ready), 1);

    // 3: chaining vs ECB on the same byte
    in_valid = 1'b1; in_data = 8'h97;
    tick(); in_valid = 1'b0;
    chk("t3_pt_cbc", 32'(pt_c), 32'h AF);
    chk("t3_pt_ecb", 32'(pt_e), 32'h 97);
    tick();
    c3 = sdes_enc(8'hAF, 8'hA4, 8'h43);
    chk("t3_ct_cbc", 32'(ifc.out_data), 32'(c3));
    chk("t3_ct_ecb", 32'(ife.out_data), 32'h 38);
    tick();

    // 4: backpressure in OUT
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    tick(); in_valid = 1'b0;
    tick();
    exp4 = sdes_enc(8'h3C ^ c3, 8'hA4, 8'h43);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_data", 32'(ifc.out_data), 32'(exp4));
      chk("t4_hold_valid", 32'(ifc.out_valid), 1);
      chk("t4_in_ready", 32'(ifc.in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t4_idle_in_ready", 32'(ifc.in_ready), 1);
    chk("t4_idle_out_valid", 32'(ifc.out_valid), 0);

    // 5: key_load priority in IDLE, ignored in OUT
    key_load = 1'b1; key_in = 10'b0111111101; iv_in = 8'h55;
    in_valid = 1'b1; in_data = 8'hFF; #1;
    chk("t5_in_blocked", 32'(ifc.in_ready), 0);
    tick(); key_load = 1'b0; in_valid = 1'b0;
    chk("t5_kr_low", 32'(kr_c), 0);
    chk("t5_pt_kept", 32'(pt_c), 32'(8'h3C ^ c3));
    tick(); tick();
    nk1 = ref_subkey(10'b0111111101, 1);
    nk2 = ref_subkey(10'b0111111101, 2);
    chk("t5_new_k1", 32'(k1_c), 32'(nk1));
    chk("t5_new_k2", 32'(k2_c), 32'(nk2));
    chk("t5_kr_high", 32'(kr_c), 1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h12;
    tick(); in_valid = 1'b0;
    tick();
    key_load = 1'b1; key_in = 10'b1111100000; iv_in = 8'hAA;
    tick(); key_load = 1'b0;
    chk("t5_k1_kept", 32'(k1_c), 32'(nk1));
    chk("t5_k2_kept", 32'(k2_c), 32'(nk2));
    chk("t5_still_out", 32'(ifc.out_valid), 1);
    chk("t5_ct_iv", 32'(ifc.out_data), 32'(sdes_enc(8'h12 ^ 8'h55, nk1, nk2)));
    out_ready = 1'b1;
    tick();
    chk("t5_idle_kr", 32'(kr_c), 1);
    tick();
    chk("t5_no_kgen", 32'(kr_c), 1);
    chk("t5_k1_final", 32'(k1_c), 32'(nk1));

    // 6: async reset during ENC
    in_valid = 1'b1; in_data = 8'h5A;
    tick(); in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("t6_pt_zero", 32'(pt_c), 0);
    chk("t6_k1_zero", 32'(k1_c), 0);
    chk("t6_k2_zero", 32'(k2_c), 0);
    chk("t6_od_zero", 32'(ifc.out_data), 0);
    chk("t6_kr_zero", 32'(kr_c), 0);
    chk("t6_ov_zero", 32'(ifc.out_valid), 0);
    tick(); rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_nokey_in_ready", 32'(ifc.in_ready), 0);
      chk("t6_nokey_out_valid", 32'(ifc.out_valid), 0);
    end
    key_load = 1'b1; key_in = 10'b1010000010; iv_in = 8'h00; #1;
    chk("t6_load_in_ready", 32'(ifc.in_ready), 0);
    tick(); key_load = 1'b0;
    tick(); tick();
    tick(); in_valid = 1'b0;
    n = 0;
    while (!ifc.out_valid && n < 8) begin
      tick();
      n++;
    end
    chk("t6_out_wait", 32'(ifc.out_valid), 1);
    chk("t6_latency", 32'(n), 1);
    chk("t6_ct", 32'(ifc.out_data), 32'(sdes_enc(8'h77, 8'hA4, 8'h43)));
    tick();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdes_cbc_feeder.md
Name: sdes_cbc_feeder

Overview:
- Sequential front-end stage that directly feeds the team's combinational S-DES encrypt datapath, and captures and returns its 8-bit ciphertext.
- Runs the 10-bit S-DES key schedule over two cycles and holds K1/K2 stable.
- Accepts plaintext bytes over a valid/ready handshake and XORs each byte with the chaining value (IV or previous ciphertext) for CBC mode.
- Presents each ciphertext byte on a valid/ready output stream.

Parameters:
CBC_EN, 1, 1 = CBC chaining; 0 = ECB, where enc_pt_o = plaintext and the chain register is unused.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
key_load  in  1  pulse: load key_in and iv_in
key_in  in  10  S-DES key, bit9 = P10 position 1
iv_in  in  8  initialisation vector
key_ready_o  out  1  subkeys valid, block is usable
in_valid  in  1  plaintext valid
in_data  in  8  plaintext byte
in_ready  out  1  plaintext accepted when in_valid & in_ready
enc_pt_o  out  8  to encrypt datapath PlainText, registered
subkey1_o  out  8  to encrypt datapath subKey1, registered
subkey2_o  out  8  to encrypt datapath subKey2, registered
enc_ct_i  in  8  from encrypt datapath CipherText
out_valid  out  1  ciphertext valid
out_data  out  8  ciphertext byte, registered
out_ready  in  1  downstream accepts when out_valid & out_ready

Behaviour:
- Reset (async, on rst high):
  - State = NOKEY.
  - All registers = 0, including chain, halves, enc_pt_o, subkeys and out_data.
  - key_ready_o, in_ready and out_valid are all 0.
- Bit numbering: position 1 = MSB.
  - P10 = 3 5 2 7 4 10 1 9 8 6.
  - P8 = 6 3 7 4 8 5 10 9.
  - LS-n rotates each 5-bit half left by n.
- FSM states: NOKEY, KGEN1, KGEN2, IDLE, ENC, OUT.
- NOKEY:
  - key_load → KGEN1; latch key and iv.
  - in_ready = 0.
- KGEN1 (1 cycle):
  - halves ← LS1(P10(key)).
  - subkey1_o ← P8(halves after LS1).
  - → KGEN2.
- KGEN2 (1 cycle):
  - halves ← LS2(halves).
  - subkey2_o ← P8(result).
  - chain ← iv.
  - → IDLE; key_ready_o = 1 from the cycle IDLE is entered.
- key_ready_o drops to 0 in the cycle after any accepted key_load and stays low until KGEN2 completes.
- IDLE:
  - in_ready = ~key_load (combinational); key_load has priority over a same-cycle in_valid.
  - key_load → KGEN1.
  - Accepted byte: enc_pt_o ← in_data ^ chain (or in_data if CBC_EN = 0); → ENC.
- ENC (1 cycle, settle time for the combinational encrypt path):
  - out_data ← enc_ct_i at end of cycle.
  - If CBC_EN: chain ← enc_ct_i.
  - → OUT.
- OUT:
  - out_valid = 1; out_data is held stable until out_ready.
  - out_ready → IDLE; the next byte can be accepted the cycle after the handshake.
  - No bypass: out_valid and in_ready are never both 1.
- Latency and throughput:
  - Input accepted at cycle N → out_valid high at N+2 (zero-wait out_ready).
  - Throughput is 1 byte per 3 cycles.
- key_load in KGEN1, KGEN2, ENC or OUT is ignored. An in-flight block always completes with the old subkeys.
- Reset mid-operation clears everything, including the pending out_data. A new key_load is required before any further input is accepted.
- enc_pt_o, subkey1_o and subkey2_o change only on the edges listed above, so the encrypt datapath inputs are glitch-free during ENC.

Decomposition:
- Shared package sdes_pkg holds:
  - P10/P8 index constants
  - the state enum
  - functions p10(), p8(), ls()
- The functions are reused by the decrypt-side feeder.
- One natural sub-module, sdes_keysched_seq: holds the KGEN1/KGEN2 logic, the halves register and the subkey registers, with start/done.
- The parent owns the FSM, chain and handshakes.
- The bench connects the team's encrypt datapath between enc_pt_o/subkey*_o and enc_ct_i.

Test Plan:
1. Reset, then key_load with key = 10'b1010000010, iv = 0 → 2 cycles later subkey1_o = 8'hA4, subkey2_o = 8'h43, key_ready_o = 1.
2. After test 1, CBC, send in_data = 8'h97 → enc_pt_o = 8'h97; out_data = 8'h38 with out_valid at N+2.
3. Second byte 8'h97 under CBC → enc_pt_o = 8'hAF (8'h97 ^ 8'h38). Same byte with CBC_EN = 0 → enc_pt_o = 8'h97, out_data = 8'h38.
4. Hold out_ready = 0 for 5 cycles in OUT → out_data stable, in_ready = 0. Raise out_ready → IDLE next cycle; in_ready = 1 when key_load = 0.
5. In IDLE assert key_load and in_valid together → byte not accepted, state KGEN1, key_ready_o = 0. key_load during OUT → ignored, subkeys unchanged.
6. Assert rst during ENC → outputs 0 immediately (async), state NOKEY; in_valid ignored until key_load completes.
